// File: rtl/io_pkg.sv
// io_pkg: shared types for the posted-write IO queue.
// Holds the slave/master state encodings and the queued entry layout.
package io_pkg;

    localparam int IO_AW = 23;
    localparam int IO_DW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POSTWAIT,
        S_DRAIN,
        S_DIRECT,
        S_WAITDONE
    } slave_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_REQ,
        M_ACT
    } master_state_t;

    // One queued IO cycle: direction, byte strobes, word address and data.
    typedef struct packed {
        logic             rw;
        logic             lds;
        logic             uds;
        logic [IO_AW-1:0] a;
        logic [IO_DW-1:0] d;
    } io_entry_t;

endpackage

// File: rtl/io_post_fifo_if.sv
// io_post_fifo_if: FSB-side request/termination, IOB master side and
// occupancy status of the posted-write queue, bundled as one port.
interface io_post_fifo_if #(
    parameter int AW = io_pkg::IO_AW,
    parameter int DW = io_pkg::IO_DW,
    parameter int CW = 3
);
    logic          REQ;
    logic          RW;
    logic          POST;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic          LDS;
    logic          UDS;
    logic          Ready;
    logic          BERR;
    logic          IOREQ;
    logic          IORW;
    logic [AW-1:0] IOA;
    logic [DW-1:0] IOD;
    logic          IOL;
    logic          IOU;
    logic          IOACT;
    logic          IOBERR;
    logic [CW-1:0] Count;
    logic          Full;
    logic          Empty;

    // The queue itself.
    modport slave (
        input  REQ, RW, POST, A, D, LDS, UDS, IOACT, IOBERR,
        output Ready, BERR, IOREQ, IORW, IOA, IOD, IOL, IOU, Count, Full, Empty
    );

    // The surrounding FSB decode and IOB bus agent.
    modport master (
        output REQ, RW, POST, A, D, LDS, UDS, IOACT, IOBERR,
        input  Ready, BERR, IOREQ, IORW, IOA, IOD, IOL, IOU, Count, Full, Empty
    );

endinterface

// File: rtl/io_fifo_mem.sv
// io_fifo_mem: DEPTH-entry circular buffer of io_entry_t with occupancy.
// A write while full is accepted only if a read retires in the same cycle.
module io_fifo_mem
    import io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  io_entry_t     wrData,
    input  logic          rdEn,
    output io_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    io_entry_t     mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic          doWr;
    logic          doRd;

    assign doRd  = rdEn && !empty;
    assign doWr  = wrEn && (!full || doRd);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

    // Entry storage.
    // NOTE: the array has no reset; Count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (doWr) mem[wrPtr] <= wrData;
    end

    // Pointers wrap naturally since DEPTH is a power of two; Count tracks net change.
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
            case ({doWr, doRd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/io_post_fifo.sv
// io_post_fifo: posted-write queue between the FSB IO slave decode and the
// IOB bus master. Postable writes are acknowledged at once and drained in
// order; reads and non-postable writes wait for the queue to empty and then
// run directly on the master.
// Optional build macro IO_POST_BERR_EN: a posted write that retires with
// IOBERR is reported as BERR on the next FSB IO request.
module io_post_fifo
    import io_pkg::*;
#(
    parameter int AW    = IO_AW,
    parameter int DW    = IO_DW,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK_FSB,
    input  logic          RES,
    io_post_fifo_if.slave bus
);
    slave_state_t  sState;
    master_state_t mState;
    io_entry_t     inEntry;
    io_entry_t     pend;
    io_entry_t     wrData;
    io_entry_t     head;
    logic          ioactQ;
    logic          ioactFall;
    logic          reqPost;
    logic          wrEn;
    logic          rdEn;
    logic          errHit;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    assign inEntry   = '{rw: bus.RW, lds: bus.LDS, uds: bus.UDS, a: bus.A, d: bus.D};
    assign ioactFall = ioactQ && !bus.IOACT;
    assign rdEn      = (mState == M_ACT) && ioactFall;
    assign reqPost   = bus.REQ && !bus.RW && bus.POST;

`ifdef IO_POST_BERR_EN
    logic postErr;
    // A retire-with-error in the same cycle as REQ must already be visible.
    assign errHit = postErr || (rdEn && bus.IOBERR);
`else
    assign errHit = 1'b0;
`endif

    io_fifo_mem #(.DEPTH(DEPTH), .CW(CW)) uMem (
        .clk    (CLK_FSB),
        .rst    (RES),
        .wrEn   (wrEn),
        .wrData (wrData),
        .rdEn   (rdEn),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign bus.Count = count;
    assign bus.Full  = full;
    assign bus.Empty = empty;

    // Enqueue select: fresh request from IDLE, or the held entry once a slot frees.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wrEn   = 1'b0;
        wrData = inEntry;
        case (sState)
            S_IDLE:     wrEn = reqPost && !full && !errHit;
            S_POSTWAIT: begin
                wrEn   = !full || rdEn;
                wrData = pend;
            end
            default:    ;
        endcase
    end

    // Slave and master FSMs sharing the registered IOB outputs and terminations.
    always_ff @(posedge CLK_FSB or posedge RES) begin
        if (RES) begin
            sState    <= S_IDLE;
            mState    <= M_IDLE;
            ioactQ    <= 1'b0;
            pend      <= '0;
            bus.Ready <= 1'b0;
            bus.BERR  <= 1'b0;
            bus.IOREQ <= 1'b0;
            bus.IORW  <= 1'b1;
            bus.IOA   <= '0;
            bus.IOD   <= '0;
            bus.IOL   <= 1'b0;
            bus.IOU   <= 1'b0;
`ifdef IO_POST_BERR_EN
            postErr   <= 1'b0;
`endif
        end else begin
            bus.Ready <= 1'b0;
            bus.BERR  <= 1'b0;
            ioactQ    <= bus.IOACT;

            case (sState)
                S_IDLE: begin
                    if (bus.REQ) begin
                        pend <= inEntry;
                        if (errHit) begin
                            bus.BERR <= 1'b1;
                        end else if (reqPost) begin
                            if (!full) bus.Ready <= 1'b1;
                            else       sState    <= S_POSTWAIT;
                        end else begin
                            sState <= S_DRAIN;
                        end
                    end
                end
                S_POSTWAIT: begin
                    if (wrEn) begin
                        bus.Ready <= 1'b1;
                        sState    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // Strict ordering: every posted write retires before this cycle issues.
                    if (empty && mState == M_IDLE) begin
                        bus.IOREQ <= 1'b1;
                        bus.IORW  <= pend.rw;
                        bus.IOA   <= pend.a;
                        bus.IOD   <= pend.d;
                        bus.IOL   <= pend.lds;
                        bus.IOU   <= pend.uds;
                        sState    <= S_DIRECT;
                    end
                end
                S_DIRECT: begin
                    if (bus.IOACT) begin
                        bus.IOREQ <= 1'b0;
                        sState    <= S_WAITDONE;
                    end
                end
                S_WAITDONE: begin
                    if (ioactFall) begin
                        if (bus.IOBERR) bus.BERR  <= 1'b1;
                        else            bus.Ready <= 1'b1;
                        sState <= S_IDLE;
                    end
                end
                default: sState <= S_IDLE;
            endcase

            case (mState)
                M_IDLE: begin
                    if (!empty && sState != S_DIRECT && sState != S_WAITDONE) begin
                        bus.IOREQ <= 1'b1;
                        bus.IORW  <= 1'b0;
                        bus.IOA   <= head.a;
                        bus.IOD   <= head.d;
                        bus.IOL   <= head.lds;
                        bus.IOU   <= head.uds;
                        mState    <= M_REQ;
                    end
                end
                M_REQ: begin
                    if (bus.IOACT) begin
                        bus.IOREQ <= 1'b0;
                        mState    <= M_ACT;
                    end
                end
                M_ACT: begin
                    if (ioactFall) mState <= M_IDLE;
                end
                default: mState <= M_IDLE;
            endcase

`ifdef IO_POST_BERR_EN
            if (rdEn && bus.IOBERR) postErr <= 1'b1;
            if (sState == S_IDLE && bus.REQ && errHit) postErr <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_io_post_fifo.sv
// tb_io_post_fifo: directed bench for io_post_fifo with a scoreboard of
// expected IOB master cycles (pushed at FSB request, popped at IOREQ).
module tb_io_post_fifo;
    import io_pkg::*;

    logic      CLK_FSB = 1'b0;
    logic      RES     = 1'b1;
    int        nPass   = 0;
    int        nTotal  = 0;
    io_entry_t sb[$];

    io_post_fifo_if bus ();

    io_post_fifo dut (
        .CLK_FSB (CLK_FSB),
        .RES     (RES),
        .bus     (bus)
    );

    always #5 CLK_FSB = ~CLK_FSB;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        nTotal++;
        assert (obs === expd) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
    endtask

    // One-cycle REQ pulse; returns at the negedge after the sampling edge.
    task automatic doReq(input logic rw, input logic post, input logic [22:0] a,
                         input logic [15:0] d, input logic expectIssue);
        io_entry_t e;
        bus.REQ  = 1'b1;
        bus.RW   = rw;
        bus.POST = post;
        bus.A    = a;
        bus.D    = d;
        bus.LDS  = 1'b1;
        bus.UDS  = d[0];
        e = '{rw: rw, lds: 1'b1, uds: d[0], a: a, d: d};
        if (expectIssue) sb.push_back(e);
        @(negedge CLK_FSB);
        bus.REQ = 1'b0;
    endtask

    // Acts as the IOB agent for one cycle; returns at the negedge after IOACT falls.
    task automatic service(input logic berr, input int lag, input int hold);
        io_entry_t e;
        int n = 0;
        while (bus.IOREQ !== 1'b1 && n < 60) begin
            @(negedge CLK_FSB);
            n++;
        end
        check("ioreq_wait", bus.IOREQ, 1);
        check("sb_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ioa", bus.IOA, e.a);
            check("iorw", bus.IORW, e.rw);
            if (!e.rw) check("iod", bus.IOD, e.d);
            check("iol_iou", {bus.IOL, bus.IOU}, {e.lds, e.uds});
        end
        repeat (lag) @(negedge CLK_FSB);
        check("ioreq_hold", bus.IOREQ, 1);
        bus.IOACT = 1'b1;
        @(negedge CLK_FSB);
        check("ioreq_drop", bus.IOREQ, 0);
        repeat (hold - 1) @(negedge CLK_FSB);
        bus.IOACT  = 1'b0;
        bus.IOBERR = berr;
        @(negedge CLK_FSB);
        bus.IOBERR = 1'b0;
    endtask

    initial begin
        bus.REQ = 0; bus.RW = 1; bus.POST = 0; bus.A = '0; bus.D = '0;
        bus.LDS = 0; bus.UDS = 0; bus.IOACT = 0; bus.IOBERR = 0;

        // Reset values
        repeat (2) @(negedge CLK_FSB);
        check("rst_ready", bus.Ready, 0);
        check("rst_berr", bus.BERR, 0);
        check("rst_ioreq", bus.IOREQ, 0);
        check("rst_iorw", bus.IORW, 1);
        check("rst_ioa", bus.IOA, 0);
        check("rst_count", bus.Count, 0);
        check("rst_flags", {bus.Empty, bus.Full}, 2'b10);
        RES = 1'b0;
        @(negedge CLK_FSB);

        // Single posted write
        doReq(1'b0, 1'b1, 23'h1000, 16'hBEEF, 1'b1);
        check("s1_ready", bus.Ready, 1);
        check("s1_count", bus.Count, 1);
        check("s1_ioreq_early", bus.IOREQ, 0);
        @(negedge CLK_FSB);
        check("s1_ioreq", bus.IOREQ, 1);
        check("s1_ready_pulse", bus.Ready, 0);
        service(1'b0, 3, 2);
        check("s1_count_done", bus.Count, 0);
        check("s1_empty", bus.Empty, 1);
        check("s1_no_ready", bus.Ready, 0);

        // Five posted writes with IOACT stalled
        for (int i = 0; i < 4; i++) begin
            doReq(1'b0, 1'b1, 23'h0100 + 23'(2 * i), 16'(16'h1110 + i), 1'b1);
            check("s2_ready", bus.Ready, 1);
            check("s2_count", bus.Count, 32'(i + 1));
        end
        check("s2_full", bus.Full, 1);
        doReq(1'b0, 1'b1, 23'h0108, 16'h5555, 1'b1);
        check("s2_stall_ready", bus.Ready, 0);
        repeat (3) @(negedge CLK_FSB);
        check("s2_stall_still", bus.Ready, 0);
        check("s2_stall_count", bus.Count, 4);
        service(1'b0, 0, 2);
        check("s2_fifth_ready", bus.Ready, 1);
        check("s2_count_kept", bus.Count, 4);
        @(negedge CLK_FSB);
        check("s2_ready_pulse", bus.Ready, 0);
        for (int i = 0; i < 4; i++) service(1'b0, 1, 1);
        check("s2_drained", bus.Count, 0);

        // Read after two posted writes: strict order
        doReq(1'b0, 1'b1, 23'h1000, 16'hA001, 1'b1);
        doReq(1'b0, 1'b1, 23'h1002, 16'hA002, 1'b1);
        doReq(1'b1, 1'b0, 23'h2000, 16'h0000, 1'b1);
        check("s3_read_no_ready", bus.Ready, 0);
        service(1'b0, 1, 2);
        check("s3_not_empty", bus.Empty, 0);
        service(1'b0, 1, 2);
        check("s3_empty", bus.Empty, 1);
        check("s3_read_waits", bus.IOREQ, 0);
        service(1'b0, 1, 2);
        check("s3_read_ready", bus.Ready, 1);
        check("s3_read_berr", bus.BERR, 0);

        // Non-postable write terminated with bus error
        @(negedge CLK_FSB);
        doReq(1'b0, 1'b0, 23'h3000, 16'h1234, 1'b1);
        check("s4_no_ready", bus.Ready, 0);
        service(1'b1, 1, 1);
        check("s4_berr", bus.BERR, 1);
        check("s4_ready", bus.Ready, 0);
        @(negedge CLK_FSB);
        check("s4_berr_pulse", bus.BERR, 0);

        // Posted write retiring with IOBERR, then a read
        doReq(1'b0, 1'b1, 23'h4000, 16'h4444, 1'b1);
        service(1'b1, 1, 2);
        check("s5_post_no_berr", bus.BERR, 0);
        @(negedge CLK_FSB);
`ifdef IO_POST_BERR_EN
        doReq(1'b1, 1'b0, 23'h5000, 16'h0000, 1'b0);
        check("s5_berr", bus.BERR, 1);
        check("s5_ready", bus.Ready, 0);
        repeat (4) @(negedge CLK_FSB);
        check("s5_no_issue", bus.IOREQ, 0);
        doReq(1'b1, 1'b0, 23'h5002, 16'h0000, 1'b1);
        service(1'b0, 1, 2);
        check("s5_cleared_ready", bus.Ready, 1);
        check("s5_cleared_berr", bus.BERR, 0);
`else
        doReq(1'b1, 1'b0, 23'h5000, 16'h0000, 1'b1);
        check("s5_no_berr", bus.BERR, 0);
        service(1'b0, 1, 2);
        check("s5_read_ready", bus.Ready, 1);
        check("s5_read_berr", bus.BERR, 0);
`endif

        // Reset mid-transfer
        @(negedge CLK_FSB);
        for (int i = 0; i < 3; i++) doReq(1'b0, 1'b1, 23'h6000 + 23'(2 * i), 16'(16'h6000 + i), 1'b1);
        check("s6_ioreq_up", bus.IOREQ, 1);
        check("s6_count3", bus.Count, 3);
        RES = 1'b1;
        #1;
        check("s6_rst_ioreq", bus.IOREQ, 0);
        check("s6_rst_count", bus.Count, 0);
        check("s6_rst_ready", bus.Ready, 0);
        sb.delete();
        @(negedge CLK_FSB);
        RES = 1'b0;
        @(negedge CLK_FSB);
        doReq(1'b0, 1'b1, 23'h7000, 16'h7777, 1'b1);
        check("s6_ready", bus.Ready, 1);
        check("s6_count", bus.Count, 1);
        @(negedge CLK_FSB);
        check("s6_ioreq", bus.IOREQ, 1);
        service(1'b0, 3, 2);
        check("s6_count_done", bus.Count, 0);
        check("s6_sb_clear", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
